parallel_mult: RTL and testbench

Binary-weight dot-product unit for the FPGA neural-network accelerator. Each cycle it takes 16 signed 16-bit input-neuron values and 16 one-bit weights, where bit 1 means +1 and bit 0 means -1. It sums the conditionally negated inputs through a fully pipelined adder tree and emits one saturated 16-bit neuron pre-activation. It sits between the neuron input buffer and the activation/output stage.

---
 rtl/parallel_mult.sv | 83 ++++++++
 tb/tb_parallel_mult.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/parallel_mult.sv
// Binary-weight dot product: 16 signed inputs, each multiplied by +1 or -1,
// summed through a registered adder tree and saturated to DATA_W bits.
module parallel_mult #(
    parameter int DATA_W = 16,
    parameter int N      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N-1:0][DATA_W-1:0]   input_neuron,
    input  logic [N-1:0]               weight_bits,
    output logic [DATA_W-1:0]          FinalOut,
    output logic                       out_valid
);

    localparam int LOG_N = $clog2(N);
    localparam int SUM_W = DATA_W + 1 + LOG_N;
    localparam int NODES = 2 * N - 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

    // Heap-ordered tree: node 0 is the root, leaves sit at N-1..2N-2, and the
    // children of node k are 2k+1 and 2k+2, so sibling leaves are inputs 2j, 2j+1.
    // Every node carries the full sum width; unused upper bits of shallow levels
    // are constant sign copies and get trimmed.
    logic signed [SUM_W-1:0] node_q [NODES];
    logic signed [SUM_W-1:0] node_d [NODES];
    logic [LOG_N:0]          valid_q;
    logic [DATA_W-1:0]       finalOut_q;
    logic [DATA_W-1:0]       finalOut_d;
    logic                    outValid_q;

    always_comb begin
        logic signed [SUM_W-1:0] ext;
        ext = '0;
        for (int k = 0; k < NODES; k++) begin
            node_d[k] = '0;
        end
        for (int k = 0; k < N - 1; k++) begin
            node_d[k] = node_q[2 * k + 1] + node_q[2 * k + 2];
        end
        for (int i = 0; i < N; i++) begin
            ext = {{(LOG_N + 1){input_neuron[i][DATA_W-1]}}, input_neuron[i]};
            node_d[N - 1 + i] = weight_bits[i] ? ext : -ext;
        end
    end

    always_comb begin
        if (node_q[0] > SAT_MAX) begin
            finalOut_d = SAT_MAX[DATA_W-1:0];
        end else if (node_q[0] < SAT_MIN) begin
            finalOut_d = SAT_MIN[DATA_W-1:0];
        end else begin
            finalOut_d = node_q[0][DATA_W-1:0];
        end
    end

    // The valid chain is one bit per level; the output register only loads
    // when a real vector reaches the root, so bubbles leave FinalOut held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NODES; k++) begin
                node_q[k] <= '0;
            end
            valid_q    <= '0;
            finalOut_q <= '0;
            outValid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NODES; k++) begin
                node_q[k] <= node_d[k];
            end
            valid_q    <= {valid_q[LOG_N-1:0], en};
            outValid_q <= valid_q[LOG_N];
            if (valid_q[LOG_N]) begin
                finalOut_q <= finalOut_d;
            end
        end
    end

    assign FinalOut  = finalOut_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_parallel_mult.sv
// Scoreboard bench for parallel_mult: the driver queues hand-computed results,
// an independent monitor pops them whenever out_valid pulses.
module tb_parallel_mult;

    typedef logic [15:0][15:0] vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    vec_t        inputNeuron;
    logic [15:0] weightBits;
    logic [15:0] finalOut;
    logic        outValid;

    logic [15:0] expQ[$];
    logic [15:0] lastExp;
    int          checks;
    int          passes;

    parallel_mult #(.DATA_W(16), .N(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .input_neuron (inputNeuron),
        .weight_bits  (weightBits),
        .FinalOut     (finalOut),
        .out_valid    (outValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t fill(input logic [15:0] v);
        vec_t r;
        for (int i = 0; i < 16; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t ramp();
        vec_t r;
        for (int i = 0; i < 16; i++) r[i] = 16'(i);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    // One accepted vector per call; the expected result is queued before the edge.
    task automatic applyStimulus(input vec_t v, input logic [15:0] w, input logic [15:0] exp);
        @(negedge clk);
        #1;
        en          = 1'b1;
        inputNeuron = v;
        weightBits  = w;
        expQ.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            en          = 1'b0;
            inputNeuron = vec_t'($urandom());
            weightBits  = 16'($urandom());
        end
    endtask

    task automatic resetCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            rst         = 1'b1;
            en          = 1'b1;
            inputNeuron = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            weightBits  = 16'($urandom());
            expQ.delete();
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
    endtask

    // Monitor: after a reset edge everything must read zero; on a valid pulse
    // pop the oldest expectation; otherwise FinalOut must hold the last result.
    initial begin
        logic rstAtEdge;
        lastExp = 16'h0000;
        forever begin
            @(posedge clk);
            rstAtEdge = rst;
            @(negedge clk);
            if (rstAtEdge) begin
                checkOutput("reset_valid", {15'b0, outValid}, 16'h0000);
                checkOutput("reset_final", finalOut, 16'h0000);
                lastExp = 16'h0000;
            end else if (outValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_result: got 0x%04h, expected no result at %0t", finalOut, $time);
                end else begin
                    lastExp = expQ.pop_front();
                    checkOutput("result", finalOut, lastExp);
                end
            end else begin
                checkOutput("hold_valid", {15'b0, outValid}, 16'h0000);
                checkOutput("hold_final", finalOut, lastExp);
            end
        end
    end

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        en          = 1'b0;
        inputNeuron = '0;
        weightBits  = '0;

        resetCycles(2);
        idle(3);

        // Mixed signs: even indices add, odd subtract -> 56 - 64 = -8.
        applyStimulus(ramp(), 16'h5555, 16'hFFF8);
        idle(9);

        // Saturation corners.
        applyStimulus(fill(16'h7FFF), 16'hFFFF, 16'h7FFF);
        applyStimulus(fill(16'h7FFF), 16'h0000, 16'h8000);
        applyStimulus(fill(16'h8000), 16'h0000, 16'h7FFF);
        applyStimulus(fill(16'h8000), 16'hFFFF, 16'h8000);
        idle(8);

        // Exact small sums.
        applyStimulus(fill(16'h0001), 16'hFFFF, 16'h0010);
        idle(2);
        applyStimulus(fill(16'h0001), 16'h00FF, 16'h0000);
        idle(2);
        applyStimulus(fill(16'h0100), 16'h0001, 16'hF200);
        idle(8);

        // Five back-to-back, two bubbles, one more.
        applyStimulus(ramp(), 16'hFFFF, 16'h0078);
        applyStimulus(fill(16'h0001), 16'hFFFF, 16'h0010);
        applyStimulus(fill(16'h0100), 16'h0001, 16'hF200);
        applyStimulus(ramp(), 16'h5555, 16'hFFF8);
        applyStimulus(fill(16'h7FFF), 16'hFFFF, 16'h7FFF);
        idle(2);
        applyStimulus(fill(16'h8000), 16'hFFFF, 16'h8000);
        idle(10);

        // Reset mid-flight: three accepted vectors must never surface.
        applyStimulus(fill(16'h7FFF), 16'hFFFF, 16'h7FFF);
        applyStimulus(fill(16'h0001), 16'hFFFF, 16'h0010);
        applyStimulus(ramp(), 16'h5555, 16'hFFF8);
        resetCycles(1);
        idle(10);
        applyStimulus(fill(16'h0100), 16'h0001, 16'hF200);
        idle(2);

        for (int c = 0; c < 30 && expQ.size() > 0; c++) begin
            idle(1);
        end
        idle(3);
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
